conv_window_gen: RTL and testbench

- Producer side of the convolution tap interface: accepts a raster-order 16-bit feature-map pixel stream and emits, one per accepted pixel, a 5-pixel vertical column packed on taps[79:0].
- The downstream convolution engine shifts these columns horizontally to form its 5x5 window.
- Supports both layer geometries: 28x28 input (state=0) and 12x12 input (state=1).
- Holds K-1 row lines in on-chip circular line buffers indexed by column.

---
 rtl/conv_window_gen.sv | 181 ++++++++++++++++++
 tb/tb_conv_window_gen.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a raster-order pixel stream into K-tall vertical
// columns (one per accepted pixel) for a downstream KxK convolution engine.
// K-1 circular line buffers, indexed by column, hold the previous rows.
// Geometry (N0 or N1 side length) is latched when a frame starts.
//
// Handshake: din is taken on every cycle where din_valid=1 and the FSM is in
// FILL or STREAM with start still high; there is no backpressure. taps and
// the indices are registered one cycle after acceptance. tvalid marks the
// cycles whose column is complete (rows K-1 and later). Columns from FILL
// still update taps, but tvalid stays low for them.
module conv_window_gen #(
    parameter int DW   = 16,
    parameter int K    = 5,
    parameter int N0   = 28,
    parameter int N1   = 12,
    parameter int NMAX = 28
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            state,
    input  logic [DW-1:0]   din,
    input  logic            din_valid,
    output logic [K*DW-1:0] taps,
    output logic            tvalid,
    output logic [4:0]      col_idx,
    output logic [4:0]      row_idx,
    output logic            frame_done,
    output logic [1:0]      o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } fsm_t;

    localparam logic [4:0] N0_W       = 5'(N0);
    localparam logic [4:0] N1_W       = 5'(N1);
    localparam logic [4:0] FILL_LAST  = 5'(K - 2);

    fsm_t              r_fsm;
    fsm_t              w_fsm_nxt;
    logic [4:0]        r_ni;
    logic [4:0]        r_col;
    logic [4:0]        r_row;
    logic [DW-1:0]     r_lb [K-1][NMAX];
    logic [K*DW-1:0]   r_taps;
    logic              r_tvalid;
    logic [4:0]        r_col_idx;
    logic [4:0]        r_row_idx;
    logic              r_last_d;
    logic              r_frame_done;

    logic              w_active;
    logic              w_accept;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_last_pix;
    logic [K*DW-1:0]   w_column;

    // A pixel is accepted only while a frame is running and start is still high;
    // a falling start on the same cycle drops the pixel.
    always_comb begin
        w_active   = (r_fsm == S_FILL) || (r_fsm == S_STREAM);
        w_accept   = w_active && start && din_valid;
        w_col_last = (r_col == r_ni - 5'd1);
        w_row_last = (r_row == r_ni - 5'd1);
        w_last_pix = w_accept && (r_fsm == S_STREAM) && w_col_last && w_row_last;
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_fsm <= S_IDLE;
        else       r_fsm <= w_fsm_nxt;
    end

    // Next-state logic; DONE waits for start to drop so frames never auto-restart.
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE: begin
                if (start) w_fsm_nxt = S_FILL;
            end
            S_FILL: begin
                if (!start)
                    w_fsm_nxt = S_IDLE;
                else if (w_accept && w_col_last && (r_row == FILL_LAST))
                    w_fsm_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (!start)          w_fsm_nxt = S_IDLE;
                else if (w_last_pix) w_fsm_nxt = S_DONE;
            end
            S_DONE: begin
                if (!start) w_fsm_nxt = S_IDLE;
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    // Latch the layer geometry on IDLE->FILL; later changes of state are ignored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_ni <= N0_W;
        else if ((r_fsm == S_IDLE) && start)
            r_ni <= state ? N1_W : N0_W;
    end

    // Column/row counters: cleared while idle or when start drops, advanced per accepted pixel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_col <= '0;
            r_row <= '0;
        end else if ((r_fsm == S_IDLE) || !start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= r_row + 5'd1;
            end else begin
                r_col <= r_col + 5'd1;
            end
        end
    end

    // Line buffers shift one row deeper at the current column; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb[0][r_col] <= din;
            for (int j = 1; j < K - 1; j++)
                r_lb[j][r_col] <= r_lb[j-1][r_col];
        end
    end

    // Assemble the column from pre-write buffer contents: oldest row on top.
    always_comb begin
        w_column           = '0;
        w_column[DW-1:0]   = din;
        for (int j = 0; j < K - 1; j++)
            w_column[(j+1)*DW +: DW] = r_lb[j][r_col];
    end

    // Output register: one-cycle latency after acceptance; taps hold when idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_taps    <= '0;
            r_tvalid  <= 1'b0;
            r_col_idx <= '0;
            r_row_idx <= '0;
        end else begin
            r_tvalid <= w_accept && (r_fsm == S_STREAM);
            if (w_accept) begin
                r_taps    <= w_column;
                r_col_idx <= r_col;
                r_row_idx <= r_row;
            end
        end
    end

    // frame_done follows the final tvalid by one cycle: two-stage delay of the last pixel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last_d     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_last_d     <= w_last_pix;
            r_frame_done <= r_last_d;
        end
    end

    assign taps        = r_taps;
    assign tvalid      = r_tvalid;
    assign col_idx     = r_col_idx;
    assign row_idx     = r_row_idx;
    assign frame_done  = r_frame_done;
    assign o_dbg_state = r_fsm;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: full frames in both geometries, gapped
// input, start abort, async reset mid-frame and DONE hold.
module tb_conv_window_gen;

    localparam int DW = 16;
    localparam int K  = 5;
    localparam int W  = 90;   // {row[4:0], col[4:0], taps[79:0]}

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rstn;
    logic            start;
    logic            state;
    logic [DW-1:0]   din;
    logic            din_valid;
    logic [K*DW-1:0] taps;
    logic            tvalid;
    logic [4:0]      col_idx;
    logic [4:0]      row_idx;
    logic            frame_done;
    logic [1:0]      dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    conv_window_gen dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .state       (state),
        .din         (din),
        .din_valid   (din_valid),
        .taps        (taps),
        .tvalid      (tvalid),
        .col_idx     (col_idx),
        .row_idx     (row_idx),
        .frame_done  (frame_done),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0]    exp_q[$];
    logic [W-1:0]    exp_e;
    int              n_checks = 0;
    int              n_errors = 0;
    int              tv_cnt, fd_cnt, last_tv_cyc, fd_cyc;
    bit              consec, prev_tv;
    logic [K*DW-1:0] first_taps, last_taps, spot_taps;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_stats();
        tv_cnt      = 0;
        fd_cnt      = 0;
        last_tv_cyc = 0;
        fd_cyc      = 0;
        consec      = 0;
        first_taps  = '0;
        last_taps   = '0;
        spot_taps   = '0;
        exp_q.delete();
    endtask

    // Expected column for pixel index i of an ni x ni frame where din = r*ni + c.
    task automatic push_exp(input int ni, input int npix);
        logic [K*DW-1:0] t;
        int r, c;
        for (int i = 0; i < npix; i++) begin
            r = i / ni;
            c = i % ni;
            if (r >= K - 1) begin
                for (int k = 0; k < K; k++)
                    t[k*DW +: DW] = 16'((r - k) * ni + c);
                exp_q.push_back({5'(r), 5'(c), t});
            end
        end
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        if (rstn && tvalid) begin
            tv_cnt++;
            last_tv_cyc = cyc;
            if (prev_tv) consec = 1;
            if (exp_q.size() == 0) begin
                check("tv_extra", 1, 0);
            end else begin
                exp_e = exp_q.pop_front();
                check("taps", taps, exp_e[79:0]);
                check("col", col_idx, exp_e[84:80]);
                check("row", row_idx, exp_e[89:85]);
            end
            if (tv_cnt == 1) first_taps = taps;
            last_taps = taps;
            if (row_idx == 5'd4 && col_idx == 5'd3) spot_taps = taps;
        end
        prev_tv = tvalid;
        if (rstn && frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input logic st);
        state = st;
        start = 1'b1;
        tick();
        check("enter_fill", dbg_state, 2'd1);
    endtask

    task automatic drive_pixels(input int first, input int npix, input bit gap);
        for (int i = first; i < first + npix; i++) begin
            din       = 16'(i);
            din_valid = 1'b1;
            tick();
            if (gap) begin
                din_valid = 1'b0;
                din       = 16'hdead;
                tick();
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic full_frame_checks(input int ntv, input logic [K*DW-1:0] exp_first);
        repeat (3) tick();
        check("tv_count", tv_cnt, ntv);
        check("fd_count", fd_cnt, 1);
        check("fd_latency", fd_cyc - last_tv_cyc, 1);
        check("first_taps", first_taps, exp_first);
        check("queue_empty", exp_q.size(), 0);
        check("state_done", dbg_state, 2'd3);
    endtask

    task automatic stop_frame();
        start = 1'b0;
        tick();
        check("state_idle", dbg_state, 2'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn      = 1'b0;
        start     = 1'b0;
        state     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        prev_tv   = 0;
        clear_stats();
        repeat (2) tick();

        // Reset state
        check("rst_taps", taps, 0);
        check("rst_tvalid", tvalid, 0);
        check("rst_col", col_idx, 0);
        check("rst_row", row_idx, 0);
        check("rst_fd", frame_done, 0);
        check("rst_state", dbg_state, 2'd0);
        rstn = 1'b1;
        tick();

        // din_valid in IDLE is ignored
        din_valid = 1'b1;
        repeat (3) tick();
        din_valid = 1'b0;
        check("idle_ignore", tvalid, 0);

        // 28x28 continuous
        clear_stats();
        push_exp(28, 784);
        begin_frame(1'b0);
        drive_pixels(0, 784, 0);
        full_frame_checks(672, {16'd0, 16'd28, 16'd56, 16'd84, 16'd112});
        check("last_taps28", last_taps, {16'd671, 16'd699, 16'd727, 16'd755, 16'd783});

        // Hold start high in DONE: no more output, no second frame_done
        din_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            din = 16'(i);
            tick();
        end
        din_valid = 1'b0;
        tick();
        check("done_hold_tv", tv_cnt, 672);
        check("done_hold_fd", fd_cnt, 1);
        check("done_hold_state", dbg_state, 2'd3);
        stop_frame();

        // 12x12 continuous
        clear_stats();
        push_exp(12, 144);
        begin_frame(1'b1);
        drive_pixels(0, 144, 0);
        full_frame_checks(96, {16'd0, 16'd12, 16'd24, 16'd36, 16'd48});
        check("spot_r4c3", spot_taps, {16'd3, 16'd15, 16'd27, 16'd39, 16'd51});
        stop_frame();

        // 28x28 with din_valid toggling
        clear_stats();
        push_exp(28, 784);
        begin_frame(1'b0);
        drive_pixels(0, 784, 1);
        full_frame_checks(672, {16'd0, 16'd28, 16'd56, 16'd84, 16'd112});
        check("gap_last", last_taps, {16'd671, 16'd699, 16'd727, 16'd755, 16'd783});
        check("gap_no_consec", consec, 0);
        stop_frame();

        // Drop start at (r10,c5) together with a valid pixel, then restart 12x12
        clear_stats();
        push_exp(28, 285);
        begin_frame(1'b0);
        drive_pixels(0, 285, 0);
        din       = 16'd285;
        din_valid = 1'b1;
        start     = 1'b0;
        state     = 1'b1;
        tick();
        din_valid = 1'b0;
        check("abort_tvalid", tvalid, 0);
        check("abort_state", dbg_state, 2'd0);
        tick();
        check("abort_tv_count", tv_cnt, 173);
        check("abort_queue", exp_q.size(), 0);
        check("abort_fd", fd_cnt, 0);

        clear_stats();
        push_exp(12, 144);
        begin_frame(1'b1);
        drive_pixels(0, 144, 0);
        full_frame_checks(96, {16'd0, 16'd12, 16'd24, 16'd36, 16'd48});
        check("restart_spot", spot_taps, {16'd3, 16'd15, 16'd27, 16'd39, 16'd51});
        stop_frame();

        // Async reset mid-STREAM
        clear_stats();
        push_exp(28, 200);
        begin_frame(1'b0);
        drive_pixels(0, 200, 0);
        @(negedge clk);
        #1;
        check("pre_rst_taps_nz", (taps != 0), 1);
        rstn  = 1'b0;
        start = 1'b0;
        #1;
        check("arst_taps", taps, 0);
        check("arst_tvalid", tvalid, 0);
        check("arst_fd", frame_done, 0);
        check("arst_col", col_idx, 0);
        check("arst_row", row_idx, 0);
        check("arst_state", dbg_state, 2'd0);
        check("arst_tv_count", tv_cnt, 88);
        check("arst_queue", exp_q.size(), 0);
        tick();
        rstn = 1'b1;
        tick();

        clear_stats();
        push_exp(28, 784);
        begin_frame(1'b0);
        drive_pixels(0, 784, 0);
        full_frame_checks(672, {16'd0, 16'd28, 16'd56, 16'd84, 16'd112});
        check("post_rst_last", last_taps, {16'd671, 16'd699, 16'd727, 16'd755, 16'd783});
        stop_frame();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
